// File: rtl/boid_neighbor_scan_ctrl.sv
// Neighbour-rule sequencer for one target boid: scans boid-state memory, classifies each
// boid by estimated distance, and returns separation sums plus visual-neighbour averages.
module boid_neighbor_scan_ctrl #(
  parameter int          N_BOIDS       = 64,
  parameter int          ADDR_W        = 6,
  parameter logic [31:0] PROTECT_RANGE = 32'd262144,
  parameter logic [31:0] VISUAL_RANGE  = 32'd1310720
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] self_idx,
  input  logic [31:0]       self_x,
  input  logic [31:0]       self_y,
  input  logic [31:0]       self_vx,
  input  logic [31:0]       self_vy,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_x,
  input  logic [31:0]       mem_y,
  input  logic [31:0]       mem_vx,
  input  logic [31:0]       mem_vy,
  output logic [31:0]       dist_a,
  output logic [31:0]       dist_b,
  input  logic [31:0]       dist_q,
  output logic [5:0]        recip_sel,
  input  logic [31:0]       recip_val,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       close_dx,
  output logic [31:0]       close_dy,
  output logic [31:0]       xvel_avg,
  output logic [31:0]       yvel_avg,
  output logic [31:0]       xpos_avg,
  output logic [31:0]       ypos_avg,
  output logic [5:0]        n_count
);

  // state  | meaning
  // IDLE   | waiting for start, results held
  // SCAN   | issuing one read per cycle, addr 0..N_BOIDS-1
  // DRAIN  | last read data arrives
  // DIVIDE | count drives reciprocal LUT, averages registered
  // DONE   | results valid until res_ready
  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_DIVIDE, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_LEFT = ADDR_W'(N_BOIDS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_left;
  logic [ADDR_W-1:0] r_self_idx;
  logic [31:0]       r_self_x, r_self_y;
  logic              r_rd_vld;
  logic [ADDR_W-1:0] r_rd_idx;
  logic [31:0]       r_cdx, r_cdy, r_sx, r_sy, r_svx, r_svy;
  logic [5:0]        r_count;

  logic [31:0] w_dx, w_dy;
  logic        w_skip, w_prot, w_vis;
  logic        w_unused;

  assign w_dx   = r_self_x - mem_x;
  assign w_dy   = r_self_y - mem_y;
  assign dist_a = r_rd_vld ? w_dx : 32'd0;
  assign dist_b = r_rd_vld ? w_dy : 32'd0;
  assign w_skip = (r_rd_idx == r_self_idx);
  assign w_prot = $signed(dist_q) < $signed(PROTECT_RANGE);
  assign w_vis  = $signed(dist_q) < $signed(VISUAL_RANGE);
  assign recip_sel = r_count;
  // Target velocity is not part of any neighbour rule.
  assign w_unused = ^{self_vx, self_vy};

  function automatic logic [31:0] avg_f(input logic [31:0] sum, input logic [31:0] recip);
    logic signed [63:0] p;
    p = 64'($signed(sum)) * 64'($signed(recip));
    return p[46:15];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_left     <= '0;
      r_self_idx <= '0;
      r_self_x   <= '0;
      r_self_y   <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_idx   <= '0;
      r_cdx      <= '0;
      r_cdy      <= '0;
      r_sx       <= '0;
      r_sy       <= '0;
      r_svx      <= '0;
      r_svy      <= '0;
      r_count    <= '0;
      busy       <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      res_valid  <= 1'b0;
      close_dx   <= '0;
      close_dy   <= '0;
      xvel_avg   <= '0;
      yvel_avg   <= '0;
      xpos_avg   <= '0;
      ypos_avg   <= '0;
      n_count    <= '0;
    end else begin
      r_rd_vld <= mem_rd_en;
      r_rd_idx <= mem_addr;

      if (r_rd_vld && !w_skip) begin
        if (w_prot) begin
          r_cdx <= r_cdx + w_dx;
          r_cdy <= r_cdy + w_dy;
        end else if (w_vis) begin
          r_sx  <= r_sx + mem_x;
          r_sy  <= r_sy + mem_y;
          r_svx <= r_svx + mem_vx;
          r_svy <= r_svy + mem_vy;
          if (r_count != 6'd31) r_count <= r_count + 6'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_self_idx <= self_idx;
            r_self_x   <= self_x;
            r_self_y   <= self_y;
            r_cdx      <= '0;
            r_cdy      <= '0;
            r_sx       <= '0;
            r_sy       <= '0;
            r_svx      <= '0;
            r_svy      <= '0;
            r_count    <= '0;
            r_left     <= LAST_LEFT;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b1;
            busy       <= 1'b1;
            r_state    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_left == '0) begin
            mem_rd_en <= 1'b0;
            r_state   <= S_DRAIN;
          end else begin
            r_left   <= r_left - 1'b1;
            mem_addr <= mem_addr + 1'b1;
          end
        end
        S_DRAIN: r_state <= S_DIVIDE;
        S_DIVIDE: begin
          close_dx  <= r_cdx;
          close_dy  <= r_cdy;
          xpos_avg  <= avg_f(r_sx, recip_val);
          ypos_avg  <= avg_f(r_sy, recip_val);
          xvel_avg  <= avg_f(r_svx, recip_val);
          yvel_avg  <= avg_f(r_svy, recip_val);
          n_count   <= r_count;
          res_valid <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/boid_neighbor_scan_ctrl.md
Name: boid_neighbor_scan_ctrl

Overview:
Sequencer that computes one boid's neighbour-rule terms for the boid accelerator. On a start pulse it streams every boid's state out of the boid-state M10k and classifies each one against the target boid. It drives an external distance estimator (alpha-max/beta-min) and an external 1/n reciprocal lookup, and accumulates the separation, alignment and cohesion sums. It returns the averaged results over a valid/ready handshake. It sits between the top-level boid update FSM and the boid-state memory.

Parameters:
N_BOIDS, 64, number of boids scanned per request; legal range 2..2^ADDR_W.
ADDR_W, 6, boid-state memory address width.
PROTECT_RANGE, 32'd262144, protected radius, fix15 (8.0).
VISUAL_RANGE, 32'd1310720, visual radius, fix15 (40.0); must exceed PROTECT_RANGE.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  request pulse; sampled only in IDLE
self_idx  in  ADDR_W  index of target boid
self_x, self_y, self_vx, self_vy  in  32 each  target state, signed fix15; captured on accepted start
busy  out  1  high in any state other than IDLE
mem_rd_en  out  1  boid-state read strobe
mem_addr  out  ADDR_W  read address
mem_x, mem_y, mem_vx, mem_vy  in  32 each  read data, valid exactly 1 cycle after mem_rd_en
dist_a, dist_b  out  32 each  dx, dy presented to external distance estimator
dist_q  in  32  estimator result, combinational from dist_a/dist_b, unsigned magnitude
recip_sel  out  6  neighbour count presented to external reciprocal LUT
recip_val  in  32  1/recip_sel, fix15, combinational; 0 when recip_sel = 0
res_valid  out  1  results valid
res_ready  in  1  consumer accepts results
close_dx, close_dy  out  32 each  separation sums, signed
xvel_avg, yvel_avg, xpos_avg, ypos_avg  out  32 each  visual-neighbour averages, signed fix15
n_count  out  6  visual neighbour count

Behaviour:
- Reset: FSM goes to IDLE. All accumulators, the count, all result outputs, res_valid, busy and mem_rd_en are set to 0. mem_addr, dist_a, dist_b and recip_sel are set to 0. Reset mid-scan aborts the request with no result produced.
- States and transitions:
  - IDLE -> SCAN on start. Capture the self_* inputs and clear all accumulators.
  - SCAN: each cycle assert mem_rd_en with mem_addr = j, for j = 0..N_BOIDS-1. After issuing j = N_BOIDS-1, go to DRAIN.
  - DRAIN: one cycle, to consume the final read.
  - DIVIDE: one cycle. Drive recip_sel = count and register the averages.
  - DONE: hold res_valid = 1 and stable outputs until res_ready = 1, then go to IDLE.
- Per-neighbour evaluation in the cycle mem_* is valid (read data of index k):
  - Skip if k == captured self_idx.
  - dx = self_x - mem_x and dy = self_y - mem_y; these drive dist_a and dist_b.
  - If dist_q < PROTECT_RANGE: close_dx += dx and close_dy += dy.
  - Else if dist_q < VISUAL_RANGE: add mem_x, mem_y, mem_vx and mem_vy into the pos/vel sums, and increment count, saturating at 31.
  - Otherwise: no update.
  - All compares are signed 32-bit, strictly less-than.
- Arithmetic rules:
  - Sums are 32-bit two's complement and wrap on overflow.
  - Each average = (sum * recip_val), computed as a 64-bit signed product, then arithmetically shifted right by 15 and truncated to 32 bits.
  - With count = 0, recip_val = 0, so every average is 0; close_* is still reported.
- Control rules:
  - mem_rd_en is 0 outside SCAN.
  - start is ignored while busy.
  - If res_ready is already high on the first DONE cycle, res_valid lasts one cycle.
- Latency: if start is accepted at cycle 0, the SCAN reads occupy cycles 1..N_BOIDS. DRAIN is cycle N_BOIDS+1, DIVIDE is N_BOIDS+2, and res_valid first rises at cycle N_BOIDS+3.
- Result outputs hold their last values in IDLE until the next DIVIDE.

Test Plan:
1. Single visual neighbour: N_BOIDS=4, PROTECT=8.0, VISUAL=40.0. Self idx0 at (0,0); boid1 at (10.0,0) with vel (1.0,2.0); boids 2,3 at (100.0,100.0). Bench LUT uses floor(2^15/n). Expect n_count=1, xpos_avg=327680, xvel_avg=32768, yvel_avg=65536, close_dx=close_dy=0, and res_valid at cycle 7.
2. Protected neighbour: boid1 at (3.0,-2.0), all others far. Expect close_dx=-98304, close_dy=65536, n_count=0, all averages 0.
3. Self-exclusion and boundary: self idx2 overlapping itself. Boid1 placed so dist_q equals exactly VISUAL_RANGE, which must be rejected. Boid3 at dist_q = PROTECT_RANGE, which is counted as visual. Expect n_count=1.
4. Saturation: N_BOIDS=40, all 39 others within visual range. Expect n_count=31 and recip_sel=31 during DIVIDE.
5. Handshake and start blocking: hold res_ready=0 for 10 cycles. Outputs and res_valid stay stable, and a start pulse during SCAN and during DONE is ignored. Raise res_ready: one handshake, then busy=0.
6. Reset mid-scan: assert reset at cycle 3. Next cycle busy=0, mem_rd_en=0, res_valid=0. A new start completes with correct results and no residue from the aborted scan.
